serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only when ready=1.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port ready  output  1  high in IDLE only; start accepted.
REQ-009 SHALL have port busy  output  1  high in RUN only.
REQ-010 SHALL have port done  output  1  one-cycle pulse in DONE state.
REQ-011 SHALL have port sum  output  WIDTH  result, valid from done pulse until next accepted start.
REQ-012 SHALL have port cout  output  1  unsigned carry-out of MSB, same validity as sum.
REQ-013 SHALL have port overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB), same validity as sum.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; transitions IDLE->RUN on start&ready, RUN->DONE after bit WIDTH-1 processed, DONE->IDLE unconditionally.
REQ-015 SHALL on accepted start latch a, b into shift registers, cin into carry register, clear bit counter to 0, clear sum/cout/overflow to 0.
REQ-016 SHALL in RUN process exactly one bit per cycle, LSB first, through a single one-bit full adder: inputs a[i], b[i], carry register; outputs sum bit and next carry.
REQ-017 SHALL shift each sum bit into sum from the MSB end so that after WIDTH RUN cycles sum[i] holds bit i.
REQ-018 SHALL record carry into bit WIDTH-1 at the cycle processing bit WIDTH-1, and on leaving RUN set cout = final carry and overflow = carry-into-MSB XOR cout.
REQ-019 SHALL have latency: accepting edge E0; RUN occupies edges E1..EWIDTH; done high in the cycle following edge EWIDTH; ready high again one cycle later.
REQ-020 SHALL ignore start while busy or done is high; operands presented then have no effect.
REQ-021 SHALL accept a start asserted in the first IDLE cycle after DONE (back-to-back operation, WIDTH+2 cycles per addition).
REQ-022 SHALL compute {cout,sum} == a + b + cin exactly for all operand values, including all-ones and zero.
REQ-023 SHALL use a bit counter of $clog2(WIDTH) bits that never wraps inside RUN.

Reset
REQ-024 SHALL on rst_n low, immediately and regardless of state: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, overflow=0, counter=0, carry=0.
REQ-025 SHALL abort an in-flight addition on reset with no done pulse; first start after rst_n rises is accepted normally.

Structure
REQ-026 SHALL place the FSM state enumeration and the default WIDTH constant in shared package serial_adder_pkg.
REQ-027 SHALL instantiate the existing one_bit_adder as its sole sub-module for the per-bit arithmetic; no other adder logic.

Verification (WIDTH=8)
REQ-028 SHALL cover a=0x5A, b=0x3C, cin=0, start -> done 8 cycles after acceptance edge, sum=0x96, cout=0, overflow=1.
REQ-029 SHALL cover a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; and a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
REQ-030 SHALL cover start pulsed with a=0x01,b=0x01 during RUN of 0x10+0x20 -> single done, sum=0x30, second request ignored.
REQ-031 SHALL cover rst_n low in RUN cycle 4 -> outputs reset asynchronously, no done; subsequent 0x03+0x04 -> sum=0x07.
REQ-032 SHALL cover back-to-back starts held high -> done pulses exactly 10 cycles apart, ready low during RUN and DONE.
REQ-033 SHALL cover random a, b, cin over at least 1000 transactions -> {cout,sum} == a+b+cin every time.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/one_bit_adder.sv
// Single-bit full adder; the only arithmetic in the serial adder datapath.
module one_bit_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one operand bit per cycle, LSB first, through a single full adder.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_co;

  one_bit_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_co;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        // carry_q is the carry into the MSB while the last bit is processed
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
